// File: rtl/dadda_mac_accum.sv
// Accumulates a programmed count of unsigned multiplier products into one wide result.
// Optional build macro SATURATE_EN: clamp on overflow instead of wrapping.
module dadda_mac_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_len;
  logic               r_ovf;
  logic               w_xfer;
  logic               w_last;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [ACC_W:0]     w_sum;

  // Once clamped, every further add carries again (or adds zero), so the clamp sticks.
  function automatic logic [ACC_W-1:0] acc_next(input logic [ACC_W:0] sum);
`ifdef SATURATE_EN
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    return sum[ACC_W-1:0];
`endif
  endfunction

  assign w_xfer    = (r_state == S_ACCUM) && prod_valid;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = (w_cnt_inc == r_len);
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (len == '0) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        if (w_xfer && w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (acc_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_len <= len;
        r_ovf <= 1'b0;
      end
    end else if (w_xfer) begin
      r_acc <= acc_next(w_sum);
      r_cnt <= w_cnt_inc;
      if (w_sum[ACC_W]) r_ovf <= 1'b1;
    end
  end

  assign prod_ready = (r_state == S_ACCUM);
  assign acc_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign acc_out    = r_acc;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_dadda_mac_accum.sv
// Directed bench for dadda_mac_accum: a default-width instance and a 17-bit one sharing stimulus.
module tb_dadda_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [15:0] prod;
  logic        prod_valid;
  logic        acc_ready;

  logic        a_prod_ready, a_acc_valid, a_busy, a_overflow;
  logic [23:0] a_acc_out;
  logic        b_prod_ready, b_acc_valid, b_busy, b_overflow;
  logic [16:0] b_acc_out;

  int checks = 0;
  int errors = 0;

`ifdef SATURATE_EN
  localparam logic [16:0] EXP_B_WIDE = 17'd131071;
`else
  localparam logic [16:0] EXP_B_WIDE = 17'd64003;
`endif

  always #5 clk = ~clk;

  dadda_mac_accum dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(a_prod_ready), .acc_out(a_acc_out),
    .acc_valid(a_acc_valid), .acc_ready(acc_ready), .busy(a_busy), .overflow(a_overflow)
  );

  dadda_mac_accum #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(b_prod_ready), .acc_out(b_acc_out),
    .acc_valid(b_acc_valid), .acc_ready(acc_ready), .busy(b_busy), .overflow(b_overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues start for one cycle; returns after the start edge (cycle 0 edge).
  task automatic kick(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  // Counts cycles from the start edge until acc_valid, bounded.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!a_acc_valid && cyc < 50) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks += 5;
    if (a_prod_ready !== 1'b0) begin errors++; $display("FAIL reset_prod_ready got %b want 0", a_prod_ready); end
    if (a_acc_valid !== 1'b0)  begin errors++; $display("FAIL reset_acc_valid got %b want 0", a_acc_valid); end
    if (a_acc_out !== 24'd0)   begin errors++; $display("FAIL reset_acc_out got %0d want 0", a_acc_out); end
    if (a_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
    if (a_overflow !== 1'b0)   begin errors++; $display("FAIL reset_overflow got %b want 0", a_overflow); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int cyc;
    prod = 16'd30;
    prod_valid = 1'b1;
    kick(8'd1);
    checks += 2;
    if (a_busy !== 1'b1)       begin errors++; $display("FAIL single_busy got %b want 1", a_busy); end
    if (a_prod_ready !== 1'b1) begin errors++; $display("FAIL single_prod_ready got %b want 1", a_prod_ready); end
    wait_valid(cyc);
    prod_valid = 1'b0;
    checks += 4;
    if (cyc !== 2)              begin errors++; $display("FAIL single_latency got %0d want 2", cyc); end
    if (a_acc_out !== 24'd30)   begin errors++; $display("FAIL single_acc_out got %0d want 30", a_acc_out); end
    if (a_overflow !== 1'b0)    begin errors++; $display("FAIL single_overflow got %b want 0", a_overflow); end
    if (a_prod_ready !== 1'b0)  begin errors++; $display("FAIL single_done_ready got %b want 0", a_prod_ready); end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    checks++;
    if (a_acc_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", a_acc_valid); end
  endtask

  task automatic test_full_products();
    int cyc;
    prod = 16'd65025;
    prod_valid = 1'b1;
    kick(8'd4);
    wait_valid(cyc);
    prod_valid = 1'b0;
    checks += 3;
    if (cyc !== 5)                begin errors++; $display("FAIL full_latency got %0d want 5", cyc); end
    if (a_acc_out !== 24'h03F804) begin errors++; $display("FAIL full_acc_out got %0d want 260100", a_acc_out); end
    if (a_overflow !== 1'b0)      begin errors++; $display("FAIL full_overflow got %b want 0", a_overflow); end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int cyc;
    prod = 16'd65025;
    prod_valid = 1'b1;
    kick(8'd3);
    step();
    step();
    checks++;
    if (b_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", b_overflow); end
    wait_valid(cyc);
    prod_valid = 1'b0;
    checks += 5;
    if (b_acc_valid !== 1'b1)     begin errors++; $display("FAIL ovf_valid got %b want 1", b_acc_valid); end
    if (b_acc_out !== EXP_B_WIDE) begin errors++; $display("FAIL ovf_acc_out got %0d want %0d", b_acc_out, EXP_B_WIDE); end
    if (b_overflow !== 1'b1)      begin errors++; $display("FAIL ovf_flag got %b want 1", b_overflow); end
    if (a_acc_out !== 24'd195075) begin errors++; $display("FAIL ovf_wide_acc got %0d want 195075", a_acc_out); end
    if (a_overflow !== 1'b0)      begin errors++; $display("FAIL ovf_wide_flag got %b want 0", a_overflow); end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  task automatic test_gaps_backpressure();
    logic        pat_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] pat_d [6] = '{16'd10, 16'd99, 16'd99, 16'd20, 16'd77, 16'd30};
    kick(8'd3);
    for (int i = 0; i < 6; i++) begin
      prod_valid = pat_v[i];
      prod = pat_d[i];
      step();
      if (i == 4) begin
        checks++;
        if (a_acc_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid got %b want 0", a_acc_valid); end
      end
    end
    // Offer further products while the result waits; they must be refused.
    prod_valid = 1'b1;
    prod = 16'd1000;
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (a_acc_valid !== 1'b1)  begin errors++; $display("FAIL gaps_hold_valid[%0d] got %b want 1", i, a_acc_valid); end
      if (a_acc_out !== 24'd60)  begin errors++; $display("FAIL gaps_hold_out[%0d] got %0d want 60", i, a_acc_out); end
      if (a_prod_ready !== 1'b0) begin errors++; $display("FAIL gaps_prod_ready[%0d] got %b want 0", i, a_prod_ready); end
      step();
    end
    prod_valid = 1'b0;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL gaps_release_busy got %b want 0", a_busy); end
  endtask

  task automatic test_len_zero();
    kick(8'd0);
    checks += 4;
    if (a_acc_valid !== 1'b1) begin errors++; $display("FAIL len0_valid got %b want 1", a_acc_valid); end
    if (a_acc_out !== 24'd0)  begin errors++; $display("FAIL len0_acc_out got %0d want 0", a_acc_out); end
    if (b_overflow !== 1'b0)  begin errors++; $display("FAIL len0_ovf_clear got %b want 0", b_overflow); end
    if (a_busy !== 1'b1)      begin errors++; $display("FAIL len0_busy got %b want 1", a_busy); end
    acc_ready = 1'b1;
    start = 1'b1;
    len = 8'd5;
    step();
    start = 1'b0;
    acc_ready = 1'b0;
    checks += 2;
    if (a_busy !== 1'b0)      begin errors++; $display("FAIL len0_start_ignored got %b want 0", a_busy); end
    if (a_acc_valid !== 1'b0) begin errors++; $display("FAIL len0_valid_drop got %b want 0", a_acc_valid); end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    prod = 16'd100;
    prod_valid = 1'b1;
    kick(8'd4);
    step();
    step();
    prod_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 5;
    if (a_prod_ready !== 1'b0) begin errors++; $display("FAIL midrst_prod_ready got %b want 0", a_prod_ready); end
    if (a_acc_valid !== 1'b0)  begin errors++; $display("FAIL midrst_acc_valid got %b want 0", a_acc_valid); end
    if (a_acc_out !== 24'd0)   begin errors++; $display("FAIL midrst_acc_out got %0d want 0", a_acc_out); end
    if (a_busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got %b want 0", a_busy); end
    if (a_overflow !== 1'b0)   begin errors++; $display("FAIL midrst_overflow got %b want 0", a_overflow); end
    prod = 16'd7;
    kick(8'd1);
    prod_valid = 1'b1;
    wait_valid(cyc);
    prod_valid = 1'b0;
    checks += 2;
    if (a_acc_valid !== 1'b1) begin errors++; $display("FAIL midrst_rerun_valid got %b want 1", a_acc_valid); end
    if (a_acc_out !== 24'd7)  begin errors++; $display("FAIL midrst_rerun_out got %0d want 7", a_acc_out); end
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len = 8'd0;
    prod = 16'd0;
    prod_valid = 1'b0;
    acc_ready = 1'b0;
    test_reset();
    test_single();
    test_full_products();
    test_overflow();
    test_gaps_backpressure();
    test_len_zero();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
